// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core. It turns load-use stalls, redirects and
// data-memory waits into per-stage enables, bubble/squash controls, a timeout flag and a stall counter.
module pipe_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int REDIR_BUB   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             haz_stall,
  input  logic [1:0]       pc_sel,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             bub_e,
  output logic             sq_d,
  output logic             mem_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_MWAIT = 3'd2;
  localparam logic [2:0] S_REDIR = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [1:0] BUB_INIT = 2'(REDIR_BUB - 1);

  logic [2:0] state_q, state_nxt;
  logic [7:0] wait_cnt, wait_nxt, wait_inc;
  logic [1:0] bub_cnt, bub_nxt, bub_dec;
  logic       mem_stall;
  logic       counted_state;

  assign mem_stall = dmem_req & ~dmem_ack;
  assign wait_inc  = wait_cnt + 8'd1;
  assign bub_dec   = bub_cnt - 2'd1;
  assign state     = state_q;
  assign mem_err   = (state_q == S_ERR);

  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_cnt;
    bub_nxt   = bub_cnt;
    en_f      = 1'b0;
    en_d      = 1'b0;
    en_e      = 1'b0;
    en_m      = 1'b0;
    en_w      = 1'b0;
    bub_e     = 1'b0;
    sq_d      = 1'b0;
    case (state_q)
      S_INIT: begin
        bub_e     = 1'b1;
        sq_d      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (mem_stall) begin
          state_nxt = S_MWAIT;
          wait_nxt  = 8'd1;
        end else if (haz_stall) begin
          // A redirect arriving with a stall is dropped; D still holds it next cycle.
          en_e  = 1'b1;
          en_m  = 1'b1;
          en_w  = 1'b1;
          bub_e = 1'b1;
        end else begin
          en_f = 1'b1;
          en_d = 1'b1;
          en_e = 1'b1;
          en_m = 1'b1;
          en_w = 1'b1;
          if (pc_sel != 2'b00) begin
            sq_d = 1'b1;
            if (REDIR_BUB > 1) begin
              state_nxt = S_REDIR;
              bub_nxt   = BUB_INIT;
            end
          end
        end
      end
      S_MWAIT: begin
        if (dmem_req && dmem_ack) begin
          en_f      = 1'b1;
          en_d      = 1'b1;
          en_e      = 1'b1;
          en_m      = 1'b1;
          en_w      = 1'b1;
          wait_nxt  = 8'd0;
          state_nxt = (bub_cnt != 2'd0) ? S_REDIR : S_RUN;
        end else begin
          wait_nxt = wait_inc;
          if (wait_inc >= TIMEOUT) state_nxt = S_ERR;
        end
      end
      S_REDIR: begin
        // A memory wait freezes the pipe but keeps the remaining bubble count.
        if (mem_stall) begin
          state_nxt = S_MWAIT;
          wait_nxt  = 8'd1;
        end else begin
          en_f    = 1'b1;
          en_d    = 1'b1;
          en_e    = 1'b1;
          en_m    = 1'b1;
          en_w    = 1'b1;
          sq_d    = 1'b1;
          bub_nxt = bub_dec;
          if (bub_dec == 2'd0) state_nxt = S_RUN;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  assign counted_state = (state_q == S_RUN) || (state_q == S_MWAIT) || (state_q == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      wait_cnt  <= 8'd0;
      bub_cnt   <= 2'd0;
      stall_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
      bub_cnt  <= bub_nxt;
      if (!en_f && counted_state && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: table-driven single-cycle vectors plus hand-written
// sequences for the memory timeout, asynchronous reset clear and stall-counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       haz_stall;
  logic [1:0] pc_sel;
  logic       dmem_req;
  logic       dmem_ack;
  logic       en_f, en_d, en_e, en_m, en_w;
  logic       bub_e, sq_d, mem_err;
  logic [2:0] state;
  logic [3:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       haz;
    logic [1:0] pc;
    logic       req;
    logic       ack;
    logic [4:0] en;
    logic       bub;
    logic       sq;
    logic [2:0] st;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  pipe_ctrl #(.CNT_W(4), .MEM_TIMEOUT(15), .REDIR_BUB(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .haz_stall (haz_stall),
    .pc_sel    (pc_sel),
    .dmem_req  (dmem_req),
    .dmem_ack  (dmem_ack),
    .en_f      (en_f),
    .en_d      (en_d),
    .en_e      (en_e),
    .en_m      (en_m),
    .en_w      (en_w),
    .bub_e     (bub_e),
    .sq_d      (sq_d),
    .mem_err   (mem_err),
    .state     (state),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic h, input logic [1:0] p, input logic rq, input logic ak);
    haz_stall = h;
    pc_sel    = p;
    dmem_req  = rq;
    dmem_ack  = ak;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, ".en"},    int'({en_f, en_d, en_e, en_m, en_w}), int'(v.en));
    check({tag, ".bub_e"}, int'(bub_e),     int'(v.bub));
    check({tag, ".sq_d"},  int'(sq_d),      int'(v.sq));
    check({tag, ".state"}, int'(state),     int'(v.st));
    check({tag, ".err"},   int'(mem_err),   int'(v.err));
    check({tag, ".cnt"},   int'(stall_cnt), int'(v.cnt));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic h, input logic [1:0] p, input logic rq, input logic ak,
                              input logic [4:0] e, input logic b, input logic s,
                              input logic [2:0] st, input logic er, input logic [3:0] c);
    vec_t v;
    v.haz = h; v.pc = p; v.req = rq; v.ack = ak;
    v.en = e; v.bub = b; v.sq = s; v.st = st; v.err = er; v.cnt = c;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Cycle-by-cycle vectors starting at the first cycle after reset release.
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b00000, 1, 1, 3'd0, 0, 4'd0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 5'b00111, 1, 0, 3'd1, 0, 4'd0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 5'b11111, 0, 1, 3'd1, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd1));
    vecs.push_back(mk(0, 2'b10, 0, 0, 5'b11111, 0, 1, 3'd1, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd1, 0, 4'd1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd2, 0, 4'd2));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd2, 0, 4'd3));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd2, 0, 4'd4));
    vecs.push_back(mk(0, 2'b00, 1, 1, 5'b11111, 0, 0, 3'd2, 0, 4'd5));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd5));
    vecs.push_back(mk(0, 2'b11, 0, 0, 5'b11111, 0, 1, 3'd1, 0, 4'd5));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd3, 0, 4'd5));
    vecs.push_back(mk(0, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd2, 0, 4'd5));
    vecs.push_back(mk(0, 2'b00, 1, 1, 5'b11111, 0, 0, 3'd2, 0, 4'd6));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd6));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 1, 3'd3, 0, 4'd6));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd6));
    vecs.push_back(mk(0, 2'b00, 0, 1, 5'b11111, 0, 0, 3'd1, 0, 4'd6));
    vecs.push_back(mk(1, 2'b00, 1, 0, 5'b00000, 0, 0, 3'd1, 0, 4'd6));
    vecs.push_back(mk(1, 2'b00, 1, 1, 5'b11111, 0, 0, 3'd2, 0, 4'd7));
    vecs.push_back(mk(1, 2'b00, 0, 0, 5'b00111, 1, 0, 3'd1, 0, 4'd7));
    vecs.push_back(mk(0, 2'b00, 0, 0, 5'b11111, 0, 0, 3'd1, 0, 4'd8));
    vecs.push_back(mk(0, 2'b00, 1, 1, 5'b11111, 0, 0, 3'd1, 0, 4'd8));

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset", mk(0, 2'b00, 0, 0, 5'b00000, 1, 1, 3'd0, 0, 4'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].haz, vecs[i].pc, vecs[i].req, vecs[i].ack);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i]);
      next_cycle();
    end

    // Memory timeout: one RUN wait cycle plus fourteen MWAIT cycles, then ERR.
    do_reset();
    next_cycle();
    apply_stimulus(1'b0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("to.first_state", int'(state), 1);
    next_cycle();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("to.wait%0d_state", k), int'(state), 2);
      next_cycle();
    end
    @(negedge clk);
    check("to.err_state", int'(state), 4);
    check("to.mem_err", int'(mem_err), 1);
    check("to.en", int'({en_f, en_d, en_e, en_m, en_w}), 0);
    check("to.cnt", int'(stall_cnt), 15);
    next_cycle();
    apply_stimulus(1'b0, 2'b00, 1'b1, 1'b1);
    repeat (3) next_cycle();
    @(negedge clk);
    check("to.late_ack_state", int'(state), 4);
    check("to.late_ack_err", int'(mem_err), 1);
    check("to.late_ack_en", int'({en_f, en_d, en_e, en_m, en_w}), 0);
    check("to.cnt_sat", int'(stall_cnt), 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.mem_err", int'(mem_err), 0);
    check("areset.state", int'(state), 0);
    check("areset.cnt", int'(stall_cnt), 0);

    // Stall counter saturation under a long load-use stall.
    do_reset();
    next_cycle();
    apply_stimulus(1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 14) check("sat.cnt14", int'(stall_cnt), 14);
      if (k == 19) check("sat.cnt19", int'(stall_cnt), 15);
      next_cycle();
    end
    @(negedge clk);
    check("sat.cnt_hold", int'(stall_cnt), 15);
    check("sat.en", int'({en_f, en_d, en_e, en_m, en_w}), 5'b00111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
